// File: rtl/chess_turn_controller.sv
// chess_turn_controller: sequences one chess turn. The flow is: select a piece,
// query the move generator, pick a target, commit the move to the board, and
// hand the turn to the other side.
// Optional macro TURN_TIMER_EN adds a per-turn forfeit timer and a time_left port.
module chess_turn_controller #(
  parameter int unsigned GEN_TIMEOUT = 64
`ifdef TURN_TIMER_EN
  ,
  parameter logic [31:0] TURN_LIMIT  = 32'd3_000_000_000
`endif
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        btn_select,
  input  logic        btn_cancel,
  input  logic [2:0]  coordX,
  input  logic [2:0]  coordY,
  input  logic        sq_occupied,
  input  logic        sq_color,
  output logic        gen_req,
  output logic [2:0]  gen_x,
  output logic [2:0]  gen_y,
  input  logic        gen_done,
  input  logic [63:0] avail_moves_in,
  output logic        commit_req,
  output logic [5:0]  old_pos,
  output logic [5:0]  new_pos,
  input  logic        commit_ack,
  output logic        player,
  output logic [63:0] highlight,
  output logic [2:0]  state,
  output logic        err,
`ifdef TURN_TIMER_EN
  output logic [31:0] time_left,
`endif
  output logic        moved
);

  localparam int unsigned          WAIT_W    = $clog2(GEN_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0]    WAIT_LAST = WAIT_W'(GEN_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_SEL = 3'd0,
    ST_GEN = 3'd1,
    ST_TGT = 3'd2,
    ST_CMT = 3'd3
  } state_t;

  state_t              r_state,      w_state_nxt;
  logic                r_player,     w_player_nxt;
  logic                r_gen_req,    w_gen_req_nxt;
  logic [2:0]          r_gen_x,      w_gen_x_nxt;
  logic [2:0]          r_gen_y,      w_gen_y_nxt;
  logic                r_commit_req, w_commit_req_nxt;
  logic [5:0]          r_old_pos,    w_old_pos_nxt;
  logic [5:0]          r_new_pos,    w_new_pos_nxt;
  logic [63:0]         r_highlight,  w_highlight_nxt;
  logic                r_err,        w_err_nxt;
  logic                r_moved,      w_moved_nxt;
  logic [WAIT_W-1:0]   r_wait,       w_wait_nxt;
  logic [5:0]          w_idx;
  logic                w_own_sq;
  logic                w_forfeit;

`ifdef TURN_TIMER_EN
  logic [31:0] r_turn_cnt, w_turn_cnt_nxt;
  logic [31:0] r_time_left;

  // Turn is over once the counter reaches the limit; it saturates there.
  assign w_forfeit = (r_turn_cnt >= TURN_LIMIT);

  // Turn counter restarts whenever the side to move changes.
  always_comb begin
    w_turn_cnt_nxt = r_turn_cnt;
    if (w_player_nxt != r_player) begin
      w_turn_cnt_nxt = '0;
    end else if (!w_forfeit) begin
      w_turn_cnt_nxt = r_turn_cnt + 32'd1;
    end
  end

  // Turn counter and remaining-time registers.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_turn_cnt  <= '0;
      r_time_left <= TURN_LIMIT;
    end else begin
      r_turn_cnt  <= w_turn_cnt_nxt;
      r_time_left <= TURN_LIMIT - w_turn_cnt_nxt;
    end
  end

  assign time_left = r_time_left;
`else
  assign w_forfeit = 1'b0;
`endif

  assign w_idx    = {coordX, coordY};
  assign w_own_sq = sq_occupied && (sq_color == r_player);

  // Next-state and next-output logic for the turn sequencer.
  always_comb begin
    w_state_nxt     = r_state;
    w_player_nxt    = r_player;
    w_gen_x_nxt     = r_gen_x;
    w_gen_y_nxt     = r_gen_y;
    w_old_pos_nxt   = r_old_pos;
    w_new_pos_nxt   = r_new_pos;
    w_highlight_nxt = r_highlight;
    w_wait_nxt      = r_wait;
    w_err_nxt       = 1'b0;
    w_moved_nxt     = 1'b0;

    case (r_state)
      ST_SEL: begin
        if (w_forfeit) begin
          w_highlight_nxt = '0;
          w_player_nxt    = ~r_player;
          w_err_nxt       = 1'b1;
        end else if (btn_select) begin
          if (w_own_sq) begin
            w_gen_x_nxt   = coordX;
            w_gen_y_nxt   = coordY;
            w_old_pos_nxt = w_idx;
            w_wait_nxt    = '0;
            w_state_nxt   = ST_GEN;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      ST_GEN: begin
        if (gen_done) begin
          if (avail_moves_in == 64'd0) begin
            w_highlight_nxt = '0;
            w_err_nxt       = 1'b1;
            w_state_nxt     = ST_SEL;
          end else begin
            w_highlight_nxt = avail_moves_in;
            w_state_nxt     = ST_TGT;
          end
        end else if (r_wait == WAIT_LAST) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = ST_SEL;
        end else begin
          w_wait_nxt = r_wait + WAIT_W'(1);
        end
      end
      ST_TGT: begin
        if (w_forfeit) begin
          w_highlight_nxt = '0;
          w_player_nxt    = ~r_player;
          w_err_nxt       = 1'b1;
          w_state_nxt     = ST_SEL;
        end else if (btn_cancel) begin
          w_highlight_nxt = '0;
          w_state_nxt     = ST_SEL;
        end else if (btn_select) begin
          if (r_highlight[w_idx]) begin
            w_new_pos_nxt = w_idx;
            w_state_nxt   = ST_CMT;
          end else if (w_own_sq) begin
            w_gen_x_nxt   = coordX;
            w_gen_y_nxt   = coordY;
            w_old_pos_nxt = w_idx;
            w_wait_nxt    = '0;
            w_state_nxt   = ST_GEN;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      ST_CMT: begin
        if (commit_ack) begin
          w_highlight_nxt = '0;
          w_player_nxt    = ~r_player;
          w_moved_nxt     = 1'b1;
          w_state_nxt     = ST_SEL;
        end
      end
      default: begin
        w_state_nxt = ST_SEL;
      end
    endcase

    w_gen_req_nxt    = (w_state_nxt == ST_GEN);
    w_commit_req_nxt = (w_state_nxt == ST_CMT);
  end

  // State and registered outputs.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_state      <= ST_SEL;
      r_player     <= 1'b0;
      r_gen_req    <= 1'b0;
      r_gen_x      <= '0;
      r_gen_y      <= '0;
      r_commit_req <= 1'b0;
      r_old_pos    <= '0;
      r_new_pos    <= '0;
      r_highlight  <= '0;
      r_err        <= 1'b0;
      r_moved      <= 1'b0;
      r_wait       <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_player     <= w_player_nxt;
      r_gen_req    <= w_gen_req_nxt;
      r_gen_x      <= w_gen_x_nxt;
      r_gen_y      <= w_gen_y_nxt;
      r_commit_req <= w_commit_req_nxt;
      r_old_pos    <= w_old_pos_nxt;
      r_new_pos    <= w_new_pos_nxt;
      r_highlight  <= w_highlight_nxt;
      r_err        <= w_err_nxt;
      r_moved      <= w_moved_nxt;
      r_wait       <= w_wait_nxt;
    end
  end

  assign state      = r_state;
  assign player     = r_player;
  assign gen_req    = r_gen_req;
  assign gen_x      = r_gen_x;
  assign gen_y      = r_gen_y;
  assign commit_req = r_commit_req;
  assign old_pos    = r_old_pos;
  assign new_pos    = r_new_pos;
  assign highlight  = r_highlight;
  assign err        = r_err;
  assign moved      = r_moved;

endmodule

// File: tb/tb_chess_turn_controller.sv
// Testbench for chess_turn_controller: directed scenarios plus randomized turns
// checked against a transaction-level model of whose turn it is and what is lit.
module tb_chess_turn_controller;

  localparam int unsigned GEN_TIMEOUT = 64;
  localparam logic [31:0] TB_LIMIT    = 32'd100;

  logic        CLOCK = 1'b0;
  logic        RESET;
  logic        btn_select, btn_cancel;
  logic [2:0]  coordX, coordY;
  logic        sq_occupied, sq_color;
  logic        gen_req;
  logic [2:0]  gen_x, gen_y;
  logic        gen_done;
  logic [63:0] avail_moves_in;
  logic        commit_req;
  logic [5:0]  old_pos, new_pos;
  logic        commit_ack;
  logic        player;
  logic [63:0] highlight;
  logic [2:0]  state;
  logic        err;
  logic        moved;
`ifdef TURN_TIMER_EN
  logic [31:0] time_left;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  bit model_player;

`ifdef TURN_TIMER_EN
  chess_turn_controller #(.GEN_TIMEOUT(GEN_TIMEOUT), .TURN_LIMIT(TB_LIMIT)) dut (
`else
  chess_turn_controller #(.GEN_TIMEOUT(GEN_TIMEOUT)) dut (
`endif
    .CLOCK(CLOCK), .RESET(RESET), .btn_select(btn_select), .btn_cancel(btn_cancel),
    .coordX(coordX), .coordY(coordY), .sq_occupied(sq_occupied), .sq_color(sq_color),
    .gen_req(gen_req), .gen_x(gen_x), .gen_y(gen_y), .gen_done(gen_done),
    .avail_moves_in(avail_moves_in), .commit_req(commit_req), .old_pos(old_pos),
    .new_pos(new_pos), .commit_ack(commit_ack), .player(player), .highlight(highlight),
    .state(state), .err(err),
`ifdef TURN_TIMER_EN
    .time_left(time_left),
`endif
    .moved(moved)
  );

  always #5 CLOCK = ~CLOCK;

  // Hard stop in case the design wedges somewhere unexpected.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic click(input logic [2:0] x, input logic [2:0] y, input logic occ,
                       input logic col, input logic sel, input logic cnl);
    coordX = x; coordY = y; sq_occupied = occ; sq_color = col;
    btn_select = sel; btn_cancel = cnl;
    step();
    btn_select = 1'b0; btn_cancel = 1'b0; sq_occupied = 1'b0;
  endtask

  task automatic gen_reply(input logic [63:0] m);
    avail_moves_in = m; gen_done = 1'b1;
    step();
    gen_done = 1'b0;
  endtask

  task automatic ack();
    commit_ack = 1'b1;
    step();
    commit_ack = 1'b0;
  endtask

  // Random bit index of m whose value equals want, or -1 if none.
  function automatic int pick(input logic [63:0] m, input bit want);
    int start = int'($urandom_range(0, 63));
    for (int i = 0; i < 64; i++) begin
      int j = (start + i) % 64;
      if (m[j] == want) return j;
    end
    return -1;
  endfunction

  function automatic logic [63:0] rand_mask();
    logic [63:0] m = {$urandom, $urandom} & {$urandom, $urandom};
    int b = int'($urandom_range(0, 63));
    if (m == 64'd0) m[b] = 1'b1;
    return m;
  endfunction

  task automatic test_reset();
    RESET = 1'b1; btn_select = 0; btn_cancel = 0; gen_done = 0; commit_ack = 0;
    sq_occupied = 0; sq_color = 0; coordX = 0; coordY = 0; avail_moves_in = '0;
    step(); step();
    RESET = 1'b0;
    model_player = 1'b0;
    n_checks++;
    if ({state, player, gen_req, commit_req, err, moved} !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got st=%0d pl=%0b gr=%0b cr=%0b err=%0b mv=%0b want all 0",
               state, player, gen_req, commit_req, err, moved);
    end
    n_checks++;
    if ({highlight, old_pos, new_pos, gen_x, gen_y} !== 82'd0) begin
      n_fail++;
      $display("FAIL reset_data: got hl=%h op=%0o np=%0o gx=%0d gy=%0d want 0",
               highlight, old_pos, new_pos, gen_x, gen_y);
    end
`ifdef TURN_TIMER_EN
    n_checks++;
    if (time_left !== TB_LIMIT) begin
      n_fail++;
      $display("FAIL reset_time_left: got %0d want %0d", time_left, TB_LIMIT);
    end
`endif
  endtask

  task automatic test_directed_turn();
    logic [63:0] m = '0;
    m[36] = 1'b1; m[44] = 1'b1;
    click(3'd6, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if ({gen_req, gen_x, gen_y, state} !== {1'b1, 3'd6, 3'd4, 3'd1}) begin
      n_fail++;
      $display("FAIL dir_gen_req: got gr=%0b gx=%0d gy=%0d st=%0d want 1 6 4 1",
               gen_req, gen_x, gen_y, state);
    end
    gen_reply(m);
    n_checks++;
    if (highlight !== m || state !== 3'd2 || gen_req !== 1'b0) begin
      n_fail++;
      $display("FAIL dir_highlight: got hl=%h st=%0d gr=%0b want hl=%h st=2 gr=0",
               highlight, state, gen_req, m);
    end
    click(3'd4, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (3) begin
      n_checks++;
      if ({commit_req, old_pos, new_pos, state} !== {1'b1, 6'o64, 6'o44, 3'd3}) begin
        n_fail++;
        $display("FAIL dir_commit: got cr=%0b op=%0o np=%0o st=%0d want 1 64 44 3",
                 commit_req, old_pos, new_pos, state);
      end
      step();
    end
    ack();
    model_player = ~model_player;
    n_checks++;
    if ({player, moved, commit_req, state} !== {model_player, 1'b1, 1'b0, 3'd0} ||
        highlight !== 64'd0) begin
      n_fail++;
      $display("FAIL dir_ack: got pl=%0b mv=%0b cr=%0b st=%0d hl=%h want %0b 1 0 0 0",
               player, moved, commit_req, state, highlight, model_player);
    end
    step();
    n_checks++;
    if (moved !== 1'b0) begin
      n_fail++;
      $display("FAIL dir_moved_pulse: got %0b want 0", moved);
    end
  endtask

  task automatic test_illegal_select();
    click(3'd1, 3'd0, 1'b1, ~model_player, 1'b1, 1'b0);
    n_checks++;
    if ({err, state, gen_req} !== {1'b1, 3'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL illegal_color: got err=%0b st=%0d gr=%0b want 1 0 0", err, state, gen_req);
    end
    click(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'b0, model_player, 1'b1, 1'b0);
    n_checks++;
    if ({err, state, gen_req} !== {1'b1, 3'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL illegal_empty: got err=%0b st=%0d gr=%0b want 1 0 0", err, state, gen_req);
    end
    click(3'd0, 3'd0, 1'b1, model_player, 1'b0, 1'b1);
    n_checks++;
    if ({err, state} !== {1'b0, 3'd0}) begin
      n_fail++;
      $display("FAIL sel_cancel_ignored: got err=%0b st=%0d want 0 0", err, state);
    end
  endtask

  task automatic test_gen_timeout();
    int n = 0;
    click(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'b1, model_player, 1'b1, 1'b0);
    while (gen_req === 1'b1 && n < 200) begin
      n++;
      step();
    end
    n_checks++;
    if (n != int'(GEN_TIMEOUT)) begin
      n_fail++;
      $display("FAIL timeout_len: got %0d gen_req cycles want %0d", n, GEN_TIMEOUT);
    end
    n_checks++;
    if ({err, state, gen_req} !== {1'b1, 3'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL timeout_err: got err=%0b st=%0d gr=%0b want 1 0 0", err, state, gen_req);
    end
    step();
    gen_reply(rand_mask());
    n_checks++;
    if (state !== 3'd0 || highlight !== 64'd0 || gen_req !== 1'b0) begin
      n_fail++;
      $display("FAIL late_gen_done: got st=%0d hl=%h gr=%0b want 0 0 0", state, highlight, gen_req);
    end
  endtask

  task automatic test_empty_mask();
    click(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'b1, model_player, 1'b1, 1'b0);
    repeat ($urandom_range(0, 5)) step();
    gen_reply(64'd0);
    n_checks++;
    if ({err, state, gen_req} !== {1'b1, 3'd0, 1'b0} || highlight !== 64'd0) begin
      n_fail++;
      $display("FAIL empty_mask: got err=%0b st=%0d gr=%0b hl=%h want 1 0 0 0",
               err, state, gen_req, highlight);
    end
  endtask

  task automatic test_cancel_priority();
    logic [63:0] m = rand_mask();
    logic [5:0]  s;
    click(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'b1, model_player, 1'b1, 1'b0);
    gen_reply(m);
    s = 6'(pick(m, 1'b1));
    click(s[5:3], s[2:0], 1'b0, 1'b0, 1'b1, 1'b1);
    n_checks++;
    if ({state, commit_req, err} !== {3'd0, 1'b0, 1'b0} || highlight !== 64'd0) begin
      n_fail++;
      $display("FAIL cancel_priority: got st=%0d cr=%0b err=%0b hl=%h want 0 0 0 0",
               state, commit_req, err, highlight);
    end
  endtask

  task automatic test_random_turns();
    for (int t = 0; t < 20; t++) begin
      logic [63:0] m = rand_mask();
      logic [5:0]  src = 6'($urandom_range(0, 63));
      logic [5:0]  dst;
      int z;
      click(src[5:3], src[2:0], 1'b1, model_player, 1'b1, 1'b0);
      repeat ($urandom_range(0, 8)) step();
      n_checks++;
      if ({gen_req, state, gen_x, gen_y} !== {1'b1, 3'd1, src}) begin
        n_fail++;
        $display("FAIL rnd_gen[%0d]: got gr=%0b st=%0d gx=%0d gy=%0d want 1 1 %0d %0d",
                 t, gen_req, state, gen_x, gen_y, src[5:3], src[2:0]);
      end
      gen_reply(m);
      z = pick(m, 1'b0);
      if (z >= 0) begin
        click(3'(z / 8), 3'(z % 8), 1'($urandom_range(0, 1)), ~model_player, 1'b1, 1'b0);
        n_checks++;
        if ({err, state} !== {1'b1, 3'd2} || highlight !== m) begin
          n_fail++;
          $display("FAIL rnd_bad_tgt[%0d]: got err=%0b st=%0d hl=%h want 1 2 %h",
                   t, err, state, highlight, m);
        end
        if ($urandom_range(0, 1) == 1) begin
          src = 6'(z);
          click(src[5:3], src[2:0], 1'b1, model_player, 1'b1, 1'b0);
          n_checks++;
          if ({state, gen_req, gen_x, gen_y} !== {3'd1, 1'b1, src}) begin
            n_fail++;
            $display("FAIL rnd_reselect[%0d]: got st=%0d gr=%0b gx=%0d gy=%0d want 1 1 %0d %0d",
                     t, state, gen_req, gen_x, gen_y, src[5:3], src[2:0]);
          end
          m = rand_mask();
          gen_reply(m);
        end
      end
      n_checks++;
      if (highlight !== m || state !== 3'd2) begin
        n_fail++;
        $display("FAIL rnd_highlight[%0d]: got hl=%h st=%0d want %h 2", t, highlight, state, m);
      end
      dst = 6'(pick(m, 1'b1));
      click(dst[5:3], dst[2:0], 1'($urandom_range(0, 1)), ~model_player, 1'b1, 1'b0);
      repeat ($urandom_range(0, 4)) step();
      n_checks++;
      if ({commit_req, state, old_pos, new_pos} !== {1'b1, 3'd3, src, dst}) begin
        n_fail++;
        $display("FAIL rnd_commit[%0d]: got cr=%0b st=%0d op=%0o np=%0o want 1 3 %0o %0o",
                 t, commit_req, state, old_pos, new_pos, src, dst);
      end
      ack();
      model_player = ~model_player;
      n_checks++;
      if ({player, moved, state, commit_req} !== {model_player, 1'b1, 3'd0, 1'b0}) begin
        n_fail++;
        $display("FAIL rnd_done[%0d]: got pl=%0b mv=%0b st=%0d cr=%0b want %0b 1 0 0",
                 t, player, moved, state, commit_req, model_player);
      end
    end
  endtask

  task automatic test_reset_in_cmt();
    logic [63:0] m = rand_mask();
    logic [5:0]  s;
    click(3'd2, 3'd5, 1'b1, model_player, 1'b1, 1'b0);
    gen_reply(m);
    s = 6'(pick(m, 1'b1));
    click(s[5:3], s[2:0], 1'b0, 1'b0, 1'b1, 1'b0);
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    model_player = 1'b0;
    n_checks++;
    if ({state, player, gen_req, commit_req, err, moved} !== 8'd0 ||
        {highlight, old_pos, new_pos} !== 76'd0) begin
      n_fail++;
      $display("FAIL reset_in_cmt: got st=%0d pl=%0b cr=%0b hl=%h op=%0o np=%0o want all 0",
               state, player, commit_req, highlight, old_pos, new_pos);
    end
    ack();
    n_checks++;
    if ({player, moved, commit_req, state} !== 6'd0) begin
      n_fail++;
      $display("FAIL stale_ack: got pl=%0b mv=%0b cr=%0b st=%0d want 0 0 0 0",
               player, moved, commit_req, state);
    end
  endtask

`ifdef TURN_TIMER_EN
  task automatic test_turn_timer();
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    repeat (int'(TB_LIMIT)) step();
    n_checks++;
    if ({player, err} !== 2'b00 || time_left !== 32'd0) begin
      n_fail++;
      $display("FAIL timer_expire: got pl=%0b err=%0b tl=%0d want 0 0 0", player, err, time_left);
    end
    step();
    n_checks++;
    if ({player, err, state} !== {1'b1, 1'b1, 3'd0} || time_left !== TB_LIMIT) begin
      n_fail++;
      $display("FAIL timer_forfeit: got pl=%0b err=%0b st=%0d tl=%0d want 1 1 0 %0d",
               player, err, state, time_left, TB_LIMIT);
    end
  endtask
`endif

  initial begin
    test_reset();
`ifdef TURN_TIMER_EN
    test_turn_timer();
`else
    test_directed_turn();
    test_illegal_select();
    test_gen_timeout();
    test_empty_mask();
    test_cancel_priority();
    test_random_turns();
    test_reset_in_cmt();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
